alu_cmd_unit: RTL and testbench

//   Command-side front end for the 4-bit combinational alu (ops 000..111).

---
 rtl/alu_cmd_unit.sv | 198 +++++++++++++++++++
 tb/tb_alu_cmd_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_unit.sv
// alu_cmd_unit: command-side front end for the 4-bit combinational ALU.
//
// Requests arrive on a valid/ready channel. Each accepted request runs on the
// embedded ALU in the same cycle. The ALU writes {result, zero, carry, tag} into
// a response FIFO, which is drained over a valid/ready response channel. An
// accumulator holds the last accepted result so commands can be chained.
// A wrapping counter records the number of accepted commands.
//
// ALU operations (the operand a is cmd_a_i, or the accumulator when cmd_acc_i=1):
//   000 ADD  a + b        carry = carry-out of bit 3
//   001 SUB  a - b        carry = borrow (a < b)
//   010 AND  011 OR  100 XOR  111 NOR   carry = 0
//   101 SLL  a << b       shift amount is the full 4-bit b; carry = 0
//   110 SRL  a >> b       shift amount is the full 4-bit b; carry = 0
//   zero = (result == 0)
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o request handshake
//   cmd_a_i, cmd_b_i        4-bit operands
//   cmd_op_i                3-bit operation code
//   cmd_acc_i               use the accumulator as operand a
//   cmd_tag_i               opaque tag echoed on the response
//   rsp_valid_o/rsp_ready_i response handshake (FIFO head)
//   rsp_result_o, rsp_zero_o, rsp_carry_o, rsp_tag_o   head entry (0 when empty)
//   acc_o                   accumulator (last accepted result)
//   cmd_count_o             accepted commands, mod 2^CNT_W
//   busy_o                  FIFO non-empty

module alu_cmd_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_a_i,
  input  logic [3:0]       cmd_b_i,
  input  logic [2:0]       cmd_op_i,
  input  logic             cmd_acc_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [3:0]       rsp_result_o,
  output logic             rsp_zero_o,
  output logic             rsp_carry_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [3:0]       acc_o,
  output logic [CNT_W-1:0] cmd_count_o,
  output logic             busy_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpSll = 3'b101,
    OpSrl = 3'b110,
    OpNor = 3'b111
  } alu_op_e;

  // State
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [3:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // FIFO storage (no reset needed: outputs are gated by occupancy)
  logic [3:0]       res_mem_q   [DEPTH];
  logic             zero_mem_q  [DEPTH];
  logic             carry_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q   [DEPTH];

  logic push, pop;
  logic fifo_empty;

  // ALU
  logic [3:0] alu_a;
  logic [4:0] alu_wide;
  logic [3:0] alu_res;
  logic       alu_zero;
  logic       alu_carry;

  always_comb begin
    alu_a     = cmd_acc_i ? acc_q : cmd_a_i;
    alu_wide  = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (alu_op_e'(cmd_op_i))
      OpAdd: begin
        alu_wide  = {1'b0, alu_a} + {1'b0, cmd_b_i};
        alu_res   = alu_wide[3:0];
        alu_carry = alu_wide[4];
      end
      OpSub: begin
        // Bit 4 of the 5-bit difference is the borrow out.
        alu_wide  = {1'b0, alu_a} - {1'b0, cmd_b_i};
        alu_res   = alu_wide[3:0];
        alu_carry = alu_wide[4];
      end
      OpAnd:   alu_res = alu_a & cmd_b_i;
      OpOr:    alu_res = alu_a | cmd_b_i;
      OpXor:   alu_res = alu_a ^ cmd_b_i;
      OpSll:   alu_res = alu_a << cmd_b_i;
      OpSrl:   alu_res = alu_a >> cmd_b_i;
      OpNor:   alu_res = ~(alu_a | cmd_b_i);
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == 4'd0);
  end

  // Handshakes: ready depends only on registered occupancy, so a full FIFO
  // being popped this cycle still refuses a push until the next cycle.
  assign fifo_empty  = (occ_q == '0);
  assign cmd_ready_o = (occ_q < DepthOcc);
  assign push        = cmd_valid_i & cmd_ready_o;
  assign pop         = ~fifo_empty & rsp_ready_i;

  // Next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      acc_d    = alu_res;
      cnt_d    = cnt_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // A write during a reset cycle is harmless: the pointers and count are cleared,
  // so the slot is never marked valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      res_mem_q[wr_ptr_q]   <= alu_res;
      zero_mem_q[wr_ptr_q]  <= alu_zero;
      carry_mem_q[wr_ptr_q] <= alu_carry;
      tag_mem_q[wr_ptr_q]   <= cmd_tag_i;
    end
  end

  // Outputs. Head data is forced to 0 while empty, so stale entries never show.
  always_comb begin
    rsp_valid_o  = ~fifo_empty;
    busy_o       = ~fifo_empty;
    rsp_result_o = '0;
    rsp_zero_o   = 1'b0;
    rsp_carry_o  = 1'b0;
    rsp_tag_o    = '0;
    if (!fifo_empty) begin
      rsp_result_o = res_mem_q[rd_ptr_q];
      rsp_zero_o   = zero_mem_q[rd_ptr_q];
      rsp_carry_o  = carry_mem_q[rd_ptr_q];
      rsp_tag_o    = tag_mem_q[rd_ptr_q];
    end
  end

  assign acc_o       = acc_q;
  assign cmd_count_o = cnt_q;

endmodule

// File: tb/tb_alu_cmd_unit.sv
module tb_alu_cmd_unit;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a, cmd_b;
  logic [2:0]       cmd_op;
  logic             cmd_acc;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_result;
  logic             rsp_zero, rsp_carry;
  logic [TAG_W-1:0] rsp_tag;
  logic [3:0]       acc;
  logic [CNT_W-1:0] cmd_count;
  logic             busy;

  alu_cmd_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .cmd_op_i     (cmd_op),
    .cmd_acc_i    (cmd_acc),
    .cmd_tag_i    (cmd_tag),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .rsp_carry_o  (rsp_carry),
    .rsp_tag_o    (rsp_tag),
    .acc_o        (acc),
    .cmd_count_o  (cmd_count),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  typedef struct {
    int res;
    int z;
    int c;
    int tag;
  } rsp_t;
  rsp_t exp_q[$];
  int   m_acc;
  int   m_cnt;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    int         res;
    int         z;
    int         c;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int r, output int z, output int c);
    c = 0;
    case (op)
      0: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
      1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (b >= 4) ? 0 : (a * (1 << b)) % 16;
      6: r = a / (1 << b);
      default: r = 15 - (a | b);
    endcase
    z = (r == 0) ? 1 : 0;
  endfunction

  task automatic drive(input bit v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input bit accf, input logic [3:0] tag,
                       input bit rr);
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_acc   = accf;
    cmd_tag   = tag;
    rsp_ready = rr;
  endtask

  // One clock: check all outputs against the model mid-cycle, then advance the
  // model by what happens at the rising edge.
  task automatic tick();
    int   r, z, c;
    bit   do_push, do_pop;
    rsp_t e;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, exp_q.size() > 0);
    chk("busy", busy, exp_q.size() > 0);
    chk("cmd_ready", cmd_ready, exp_q.size() < DEPTH);
    chk("acc", acc, m_acc);
    chk("cmd_count", cmd_count, m_cnt);
    if (exp_q.size() > 0) begin
      chk("head_result", rsp_result, exp_q[0].res);
      chk("head_zero", rsp_zero, exp_q[0].z);
      chk("head_carry", rsp_carry, exp_q[0].c);
      chk("head_tag", rsp_tag, exp_q[0].tag);
    end else begin
      chk("empty_data", {rsp_result, rsp_zero, rsp_carry, rsp_tag}, 0);
    end
    do_push = !rst && cmd_valid && (exp_q.size() < DEPTH);
    do_pop  = !rst && rsp_ready && (exp_q.size() > 0);
    r = 0; z = 0; c = 0;
    if (do_push) ref_alu(cmd_acc ? m_acc : int'(cmd_a), int'(cmd_b), int'(cmd_op), r, z, c);
    e = '{r, z, c, int'(cmd_tag)};
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      m_acc = 0;
      m_cnt = 0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(e);
        m_acc = r;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  endtask

  initial begin
    int chain_exp[3];
    int cnt_before;
    int s;

    vecs[0]  = '{4'h5, 4'h3, 3'd0, 8,  0, 0};
    vecs[1]  = '{4'hF, 4'h1, 3'd0, 0,  1, 1};
    vecs[2]  = '{4'h5, 4'h5, 3'd1, 0,  1, 0};
    vecs[3]  = '{4'h3, 4'h5, 3'd1, 14, 0, 1};
    vecs[4]  = '{4'hC, 4'hA, 3'd2, 8,  0, 0};
    vecs[5]  = '{4'hC, 4'hA, 3'd3, 14, 0, 0};
    vecs[6]  = '{4'hF, 4'hF, 3'd4, 0,  1, 0};
    vecs[7]  = '{4'h3, 4'h2, 3'd5, 12, 0, 0};
    vecs[8]  = '{4'h1, 4'h4, 3'd5, 0,  1, 0};
    vecs[9]  = '{4'h8, 4'h3, 3'd6, 1,  0, 0};
    vecs[10] = '{4'h5, 4'hA, 3'd7, 0,  1, 0};
    vecs[11] = '{4'h0, 4'h0, 3'd7, 15, 0, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    chk("reset_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);

    // Directed single operations, each checked one cycle after acceptance
    for (int i = 0; i < 12; i++) begin
      drive(1, vecs[i].a, vecs[i].b, vecs[i].op, 0, 4'(i), 0);
      tick();
      chk("vec_valid", rsp_valid, 1);
      chk("vec_result", rsp_result, vecs[i].res);
      chk("vec_zero", rsp_zero, vecs[i].z);
      chk("vec_carry", rsp_carry, vecs[i].c);
      chk("vec_tag", rsp_tag, i % 16);
      chk("vec_acc", acc, vecs[i].res);
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
    end

    // Chaining through the accumulator without popping in between
    chain_exp[0] = 3; chain_exp[1] = 6; chain_exp[2] = 12;
    drive(1, 4'h1, 4'h2, 3'd0, 0, 4'hA, 0); tick();
    chk("chain_acc0", acc, 3);
    drive(1, 4'h0, 4'h5, 3'd4, 1, 4'hB, 0); tick();
    chk("chain_acc1", acc, 6);
    drive(1, 4'h0, 4'h1, 3'd5, 1, 4'hC, 0); tick();
    chk("chain_acc2", acc, 12);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      chk("chain_order", rsp_result, chain_exp[k]);
      tick();
    end

    // Fill to DEPTH with the consumer stalled, then hold a fifth request
    cnt_before = m_cnt;
    for (int k = 0; k < 4; k++) begin
      drive(1, 4'(k), 4'h1, 3'd0, 0, 4'(k), 0);
      tick();
    end
    chk("full_ready", cmd_ready, 0);
    drive(1, 4'h7, 4'h7, 3'd0, 0, 4'h5, 0);
    repeat (3) tick();
    chk("held_count", cmd_count, cnt_before + 4);
    chk("held_head_tag", rsp_tag, 0);
    drive(1, 4'h7, 4'h7, 3'd0, 0, 4'h5, 1);
    tick();  // full: pop only, request still refused
    chk("freed_ready", cmd_ready, 1);
    tick();  // fifth accepted now
    chk("fifth_count", cmd_count, cnt_before + 5);
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (6) tick();

    // Steady stream: one accept and one pop per cycle; count wraps after 256
    s = m_cnt;
    for (int k = 0; k < 256; k++) begin
      drive(1, 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 4'($urandom), 1);
      tick();
    end
    chk("count_wrap", cmd_count, s);
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();

    // Reset with three entries queued and a request presented in the reset cycle
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'h9, 4'(k), 3'd0, 0, 4'(k + 8), 0);
      tick();
    end
    rst = 1'b1;
    drive(1, 4'h2, 4'h2, 3'd0, 0, 4'hF, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_ready", cmd_ready, 1);
    repeat (4) tick();

    // Randomized traffic, occasional reset
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
            1'($urandom), 4'($urandom), 1'($urandom));
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
